// File: rtl/lieat_axi_pkg.sv
// Shared definitions for the LSU-to-AXI bridge: data widths,
// the AXI transaction ID used by the LSU, and the bridge FSM state encoding.
package lieat_axi_pkg;

    localparam int XLEN = 32;
    localparam int DW   = 2 * XLEN;

    localparam logic [3:0] LSU_AXI_ID = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_AR   = 3'd1,
        ST_RD_R    = 3'd2,
        ST_WR_AW_W = 3'd3,
        ST_WR_B    = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

endpackage

// File: rtl/lieat_lsu_axi_bridge_if.sv
// Handshake bundles for the bridge.
// lieat_lsu_if: LSU request/response (master = LSU, slave = bridge).
// lieat_axi_if: AXI AR/R/AW/W/B channels (master = bridge, slave = memory).
interface lieat_lsu_if;
    import lieat_axi_pkg::*;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [XLEN-1:0] lsu_req_addr;
    logic            lsu_req_wen;
    logic [2:0]      lsu_req_size;
    logic [DW-1:0]   lsu_req_wdata;
    logic            lsu_rsp_valid;
    logic            lsu_rsp_ready;
    logic [DW-1:0]   lsu_rsp_rdata;

    modport master (
        output lsu_req_valid, lsu_req_addr, lsu_req_wen,
        output lsu_req_size, lsu_req_wdata, lsu_rsp_ready,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata
    );

    modport slave (
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen,
        input  lsu_req_size, lsu_req_wdata, lsu_rsp_ready,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata
    );
endinterface

interface lieat_axi_if;
    import lieat_axi_pkg::*;

    logic            sram_axi_arvalid;
    logic            sram_axi_arready;
    logic [XLEN-1:0] sram_axi_araddr;
    logic [2:0]      sram_axi_arsize;
    logic [3:0]      sram_axi_arid;
    logic            sram_axi_rvalid;
    logic            sram_axi_rready;
    logic [DW-1:0]   sram_axi_rdata;
    logic [3:0]      sram_axi_rid;
    logic            sram_axi_awvalid;
    logic            sram_axi_awready;
    logic [XLEN-1:0] sram_axi_awaddr;
    logic [2:0]      sram_axi_awsize;
    logic            sram_axi_wvalid;
    logic            sram_axi_wready;
    logic [DW-1:0]   sram_axi_wdata;
    logic            sram_axi_bvalid;
    logic            sram_axi_bready;

    modport master (
        output sram_axi_arvalid, sram_axi_araddr, sram_axi_arsize,
        output sram_axi_arid, sram_axi_rready,
        output sram_axi_awvalid, sram_axi_awaddr, sram_axi_awsize,
        output sram_axi_wvalid, sram_axi_wdata, sram_axi_bready,
        input  sram_axi_arready, sram_axi_rvalid, sram_axi_rdata,
        input  sram_axi_rid, sram_axi_awready, sram_axi_wready,
        input  sram_axi_bvalid
    );

    modport slave (
        input  sram_axi_arvalid, sram_axi_araddr, sram_axi_arsize,
        input  sram_axi_arid, sram_axi_rready,
        input  sram_axi_awvalid, sram_axi_awaddr, sram_axi_awsize,
        input  sram_axi_wvalid, sram_axi_wdata, sram_axi_bready,
        output sram_axi_arready, sram_axi_rvalid, sram_axi_rdata,
        output sram_axi_rid, sram_axi_awready, sram_axi_wready,
        output sram_axi_bvalid
    );
endinterface

// File: rtl/lieat_general_dfflr.sv
// Load-enabled flop with asynchronous active-high reset to zero.
// Ports: clk_i, rst_i, lden_i (load enable), dnxt_i (next value), qout_o.
module lieat_general_dfflr #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lden_i,
    input  logic [WIDTH-1:0] dnxt_i,
    output logic [WIDTH-1:0] qout_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            qout_o <= '0;
        end else if (lden_i) begin
            qout_o <= dnxt_i;
        end
    end

endmodule

// File: rtl/lieat_lsu_axi_bridge.sv
// Converts single LSU load/store requests into AXI transactions,
// one outstanding at a time. Ports: clk_i, rst_i, lsu_s (LSU side),
// axi_m (AXI master side). All valid/ready outputs decode registers only.
module lieat_lsu_axi_bridge
    import lieat_axi_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    lieat_lsu_if.slave  lsu_s,
    lieat_axi_if.master axi_m
);

    logic [2:0]      state_q, state_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      size_q;
    logic            wen_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            req_hs;
    logic            rdata_en;

    assign req_hs = lsu_s.lsu_req_valid && (state_q == ST_IDLE);

    lieat_general_dfflr #(.WIDTH(3)) u_state (
        .clk_i(clk_i), .rst_i(rst_i), .lden_i(1'b1),
        .dnxt_i(state_d), .qout_o(state_q)
    );
    lieat_general_dfflr #(.WIDTH(1)) u_aw_done (
        .clk_i(clk_i), .rst_i(rst_i), .lden_i(1'b1),
        .dnxt_i(aw_done_d), .qout_o(aw_done_q)
    );
    lieat_general_dfflr #(.WIDTH(1)) u_w_done (
        .clk_i(clk_i), .rst_i(rst_i), .lden_i(1'b1),
        .dnxt_i(w_done_d), .qout_o(w_done_q)
    );
    lieat_general_dfflr #(.WIDTH(XLEN)) u_addr (
        .clk_i(clk_i), .rst_i(rst_i), .lden_i(req_hs),
        .dnxt_i(lsu_s.lsu_req_addr), .qout_o(addr_q)
    );
    lieat_general_dfflr #(.WIDTH(3)) u_size (
        .clk_i(clk_i), .rst_i(rst_i), .lden_i(req_hs),
        .dnxt_i(lsu_s.lsu_req_size), .qout_o(size_q)
    );
    lieat_general_dfflr #(.WIDTH(1)) u_wen (
        .clk_i(clk_i), .rst_i(rst_i), .lden_i(req_hs),
        .dnxt_i(lsu_s.lsu_req_wen), .qout_o(wen_q)
    );
    lieat_general_dfflr #(.WIDTH(DW)) u_wdata (
        .clk_i(clk_i), .rst_i(rst_i), .lden_i(req_hs),
        .dnxt_i(lsu_s.lsu_req_wdata), .qout_o(wdata_q)
    );
    lieat_general_dfflr #(.WIDTH(DW)) u_rdata (
        .clk_i(clk_i), .rst_i(rst_i), .lden_i(rdata_en),
        .dnxt_i(axi_m.sram_axi_rdata), .qout_o(rdata_q)
    );

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lsu_s.lsu_req_valid) begin
                    state_d   = lsu_s.lsu_req_wen ? ST_WR_AW_W : ST_RD_AR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_RD_AR: begin
                if (axi_m.sram_axi_arready) begin
                    state_d = ST_RD_R;
                end
            end
            ST_RD_R: begin
                // Beats carrying another master's ID are drained and dropped.
                if (axi_m.sram_axi_rvalid &&
                    (axi_m.sram_axi_rid == LSU_AXI_ID)) begin
                    rdata_en = 1'b1;
                    state_d  = ST_RSP;
                end
            end
            ST_WR_AW_W: begin
                // Ready is only meaningful while the matching valid is up,
                // and valid is up exactly while its done flag is clear.
                aw_done_d = aw_done_q | axi_m.sram_axi_awready;
                w_done_d  = w_done_q | axi_m.sram_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_WR_B: begin
                if (axi_m.sram_axi_bvalid) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (lsu_s.lsu_req_ready == 1'b0 && lsu_s.lsu_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign lsu_s.lsu_req_ready = (state_q == ST_IDLE);
    assign lsu_s.lsu_rsp_valid = (state_q == ST_RSP);
    assign lsu_s.lsu_rsp_rdata = wen_q ? '0 : rdata_q;

    assign axi_m.sram_axi_arvalid = (state_q == ST_RD_AR);
    assign axi_m.sram_axi_araddr  = addr_q;
    assign axi_m.sram_axi_arsize  = size_q;
    assign axi_m.sram_axi_arid    = LSU_AXI_ID;
    assign axi_m.sram_axi_rready  = (state_q == ST_RD_R);

    assign axi_m.sram_axi_awvalid = (state_q == ST_WR_AW_W) && !aw_done_q;
    assign axi_m.sram_axi_awaddr  = addr_q;
    assign axi_m.sram_axi_awsize  = size_q;
    assign axi_m.sram_axi_wvalid  = (state_q == ST_WR_AW_W) && !w_done_q;
    assign axi_m.sram_axi_wdata   = wdata_q;
    assign axi_m.sram_axi_bready  = (state_q == ST_WR_B);

endmodule

// File: tb/tb_lieat_lsu_axi_bridge.sv
// Self-checking bench for lieat_lsu_axi_bridge: a vector table of LSU
// transactions with slave timing, plus hand sequences for reset cases.
module tb_lieat_lsu_axi_bridge;
    import lieat_axi_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_err;

    lieat_lsu_if lsu ();
    lieat_axi_if axi ();

    lieat_lsu_axi_bridge dut (
        .clk_i(clk),
        .rst_i(rst),
        .lsu_s(lsu.slave),
        .axi_m(axi.master)
    );

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
        bit          has_junk;
        logic [63:0] junk;
        int          ar_dly;
        int          aw_dly;
        int          w_dly;
        int          stall;
        logic [63:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          c0;
        int          t;
        bit          aw_seen;
        bit          w_seen;
        logic [63:0] e;
        chk("req_ready_idle", 64'(lsu.lsu_req_ready), 64'd1);
        lsu.lsu_req_valid = 1'b1;
        lsu.lsu_req_addr  = v.addr;
        lsu.lsu_req_wen   = v.wen;
        lsu.lsu_req_size  = v.size;
        lsu.lsu_req_wdata = v.data;
        exp_q.push_back(v.exp_rdata);
        tick();
        c0 = cyc;
        lsu.lsu_req_valid = 1'b0;
        chk("req_ready_busy", 64'(lsu.lsu_req_ready), 64'd0);
        if (!v.wen) begin
            chk("awvalid_on_read", 64'(axi.sram_axi_awvalid), 64'd0);
            for (int k = 0; k <= v.ar_dly; k++) begin
                chk("arvalid", 64'(axi.sram_axi_arvalid), 64'd1);
                chk("araddr", 64'(axi.sram_axi_araddr), 64'(v.addr));
                chk("arsize", 64'(axi.sram_axi_arsize), 64'(v.size));
                chk("arid", 64'(axi.sram_axi_arid), 64'd2);
                axi.sram_axi_arready = (k == v.ar_dly);
                tick();
                axi.sram_axi_arready = 1'b0;
            end
            chk("arvalid_drop", 64'(axi.sram_axi_arvalid), 64'd0);
            chk("rready", 64'(axi.sram_axi_rready), 64'd1);
            if (v.has_junk) begin
                axi.sram_axi_rvalid = 1'b1;
                axi.sram_axi_rid    = 4'h1;
                axi.sram_axi_rdata  = v.junk;
                tick();
                chk("rready_after_junk", 64'(axi.sram_axi_rready), 64'd1);
                chk("no_rsp_on_junk", 64'(lsu.lsu_rsp_valid), 64'd0);
            end
            axi.sram_axi_rvalid = 1'b1;
            axi.sram_axi_rid    = 4'h2;
            axi.sram_axi_rdata  = v.data;
            tick();
            axi.sram_axi_rvalid = 1'b0;
            axi.sram_axi_rid    = 4'h0;
            axi.sram_axi_rdata  = '0;
        end else begin
            chk("arvalid_on_write", 64'(axi.sram_axi_arvalid), 64'd0);
            aw_seen = 1'b0;
            w_seen  = 1'b0;
            t       = 0;
            while (!(aw_seen && w_seen) && t < 20) begin
                chk("awvalid", 64'(axi.sram_axi_awvalid), 64'(!aw_seen));
                chk("wvalid", 64'(axi.sram_axi_wvalid), 64'(!w_seen));
                axi.sram_axi_awready = (t == v.aw_dly);
                axi.sram_axi_wready  = (t == v.w_dly);
                if (axi.sram_axi_awready) begin
                    chk("awaddr", 64'(axi.sram_axi_awaddr), 64'(v.addr));
                    chk("awsize", 64'(axi.sram_axi_awsize), 64'(v.size));
                end
                if (axi.sram_axi_wready) begin
                    chk("wdata", axi.sram_axi_wdata, v.data);
                end
                tick();
                if (axi.sram_axi_awready) aw_seen = 1'b1;
                if (axi.sram_axi_wready) w_seen = 1'b1;
                axi.sram_axi_awready = 1'b0;
                axi.sram_axi_wready  = 1'b0;
                t++;
            end
            chk("aw_w_beats", 64'({aw_seen, w_seen}), 64'd3);
            chk("bready", 64'(axi.sram_axi_bready), 64'd1);
            chk("awvalid_done", 64'(axi.sram_axi_awvalid), 64'd0);
            chk("wvalid_done", 64'(axi.sram_axi_wvalid), 64'd0);
            axi.sram_axi_bvalid = 1'b1;
            tick();
            axi.sram_axi_bvalid = 1'b0;
            chk("bready_drop", 64'(axi.sram_axi_bready), 64'd0);
        end
        t = 0;
        while (!lsu.lsu_rsp_valid && t < 20) begin
            tick();
            t++;
        end
        chk("rsp_latency", 64'(cyc - c0), 64'(v.exp_lat));
        e = exp_q.pop_front();
        for (int s = 0; s < v.stall; s++) begin
            chk("rsp_valid_hold", 64'(lsu.lsu_rsp_valid), 64'd1);
            chk("rsp_rdata_hold", lsu.lsu_rsp_rdata, e);
            chk("req_ready_in_rsp", 64'(lsu.lsu_req_ready), 64'd0);
            tick();
        end
        lsu.lsu_rsp_ready = 1'b1;
        chk("rsp_valid", 64'(lsu.lsu_rsp_valid), 64'd1);
        chk("rsp_rdata", lsu.lsu_rsp_rdata, e);
        tick();
        lsu.lsu_rsp_ready = 1'b0;
        chk("rsp_done", 64'(lsu.lsu_rsp_valid), 64'd0);
        chk("req_ready_after", 64'(lsu.lsu_req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc   = 0;
        n_chk = 0;
        n_err = 0;
        // wen addr size data junk? junk ar aw w stall exp_rdata exp_lat
        vecs[0] = '{1'b0, 32'h8000_0010, 3'd3, 64'h1122334455667788,
                    1'b0, 64'h0, 0, 0, 0, 0, 64'h1122334455667788, 2};
        vecs[1] = '{1'b1, 32'h8000_0020, 3'd2, 64'h00000000DEADBEEF,
                    1'b0, 64'h0, 0, 0, 3, 0, 64'h0, 5};
        vecs[2] = '{1'b0, 32'h8000_0100, 3'd0, 64'h00000000000000A5,
                    1'b1, 64'hBADBADBADBADBAD0, 2, 0, 0, 0,
                    64'h00000000000000A5, 5};
        vecs[3] = '{1'b0, 32'h8000_0008, 3'd1, 64'h000000000000CAFE,
                    1'b0, 64'h0, 1, 0, 0, 5, 64'h000000000000CAFE, 3};
        vecs[4] = '{1'b1, 32'h8000_0030, 3'd3, 64'h0123456789ABCDEF,
                    1'b0, 64'h0, 0, 2, 0, 0, 64'h0, 4};
        vecs[5] = '{1'b1, 32'h8000_0044, 3'd0, 64'h000000000000005A,
                    1'b0, 64'h0, 0, 1, 1, 2, 64'h0, 3};
        vecs[6] = '{1'b0, 32'h8000_0003, 3'd3, 64'hFFEEDDCCBBAA9988,
                    1'b1, 64'h0, 0, 0, 0, 0, 64'hFFEEDDCCBBAA9988, 3};
        vecs[7] = '{1'b1, 32'h8000_0051, 3'd1, 64'h0000000000001234,
                    1'b0, 64'h0, 0, 0, 0, 1, 64'h0, 2};

        rst = 1'b1;
        lsu.lsu_req_valid    = 1'b0;
        lsu.lsu_req_addr     = '0;
        lsu.lsu_req_wen      = 1'b0;
        lsu.lsu_req_size     = '0;
        lsu.lsu_req_wdata    = '0;
        lsu.lsu_rsp_ready    = 1'b0;
        axi.sram_axi_arready = 1'b0;
        axi.sram_axi_rvalid  = 1'b0;
        axi.sram_axi_rdata   = '0;
        axi.sram_axi_rid     = '0;
        axi.sram_axi_awready = 1'b0;
        axi.sram_axi_wready  = 1'b0;
        axi.sram_axi_bvalid  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_req_ready", 64'(lsu.lsu_req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(lsu.lsu_rsp_valid), 64'd0);
        chk("rst_rsp_rdata", lsu.lsu_rsp_rdata, 64'd0);
        chk("rst_arvalid", 64'(axi.sram_axi_arvalid), 64'd0);
        chk("rst_rready", 64'(axi.sram_axi_rready), 64'd0);
        chk("rst_awvalid", 64'(axi.sram_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(axi.sram_axi_wvalid), 64'd0);
        chk("rst_bready", 64'(axi.sram_axi_bready), 64'd0);
        chk("rst_araddr", 64'(axi.sram_axi_araddr), 64'd0);
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while waiting on the R channel abandons the read.
        lsu.lsu_req_valid = 1'b1;
        lsu.lsu_req_addr  = 32'h8000_0200;
        lsu.lsu_req_wen   = 1'b0;
        lsu.lsu_req_size  = 3'd3;
        tick();
        lsu.lsu_req_valid    = 1'b0;
        axi.sram_axi_arready = 1'b1;
        tick();
        axi.sram_axi_arready = 1'b0;
        chk("pre_rst_rready", 64'(axi.sram_axi_rready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_rready", 64'(axi.sram_axi_rready), 64'd0);
        chk("mid_rst_req_ready", 64'(lsu.lsu_req_ready), 64'd1);
        chk("mid_rst_rsp_valid", 64'(lsu.lsu_rsp_valid), 64'd0);
        chk("mid_rst_arvalid", 64'(axi.sram_axi_arvalid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_rsp_after_rst", 64'(lsu.lsu_rsp_valid), 64'd0);
        end

        run_vec(vecs[0]);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lieat_lsu_axi_bridge.md
LIEAT_LSU_AXI_BRIDGE -- requirements
Module: lieat_lsu_axi_bridge

Interface
REQ-001 SHALL: clock  input  1  single clock, all state on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: lsu_req_valid  input  1  LSU request valid.
REQ-004 SHALL: lsu_req_ready  output  1  bridge accepts request.
REQ-005 SHALL: lsu_req_addr  input  `XLEN  byte address.
REQ-006 SHALL: lsu_req_wen  input  1  1=write, 0=read.
REQ-007 SHALL: lsu_req_size  input  3  AXI size code (0..3 = 1/2/4/8 bytes).
REQ-008 SHALL: lsu_req_wdata  input  `XLEN*2  write data, unshifted.
REQ-009 SHALL: lsu_rsp_valid  output  1  response valid.
REQ-010 SHALL: lsu_rsp_ready  input  1  LSU accepts response.
REQ-011 SHALL: lsu_rsp_rdata  output  `XLEN*2  read data (0 for writes).
REQ-012 SHALL: sram_axi_arvalid/arready  output/input  1 each  AR handshake.
REQ-013 SHALL: sram_axi_araddr  output  `XLEN; sram_axi_arsize  output  3; sram_axi_arid  output  4.
REQ-014 SHALL: sram_axi_rvalid/rready  input/output  1 each; sram_axi_rdata  input  `XLEN*2; sram_axi_rid  input  4.
REQ-015 SHALL: sram_axi_awvalid/awready  output/input  1 each; sram_axi_awaddr  output  `XLEN; sram_axi_awsize  output  3.
REQ-016 SHALL: sram_axi_wvalid/wready  output/input  1 each; sram_axi_wdata  output  `XLEN*2.
REQ-017 SHALL: sram_axi_bvalid/bready  input/output  1 each; bresp/bid not consumed.

Function
REQ-018 SHALL: FSM states IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RSP; one outstanding transaction max.
REQ-019 SHALL: lsu_req_ready = (state==IDLE); on req handshake register addr/size/wen/wdata, go RD_AR (wen=0) or WR_AW_W (wen=1).
REQ-020 SHALL: RD_AR: arvalid=1 with registered addr/size, arid=LSU_AXI_ID; held stable until arready; on handshake -> RD_R.
REQ-021 SHALL: RD_R: rready=1; beat with rid==LSU_AXI_ID captures rdata -> RSP; beat with other rid accepted and discarded, stay RD_R.
REQ-022 SHALL: WR_AW_W: awvalid and wvalid asserted together; each drops independently after its own handshake (aw_done/w_done flags); same-cycle or either-order completion legal; both done -> WR_B.
REQ-023 SHALL: WR_B: bready=1; on bvalid -> RSP with rdata=0.
REQ-024 SHALL: RSP: lsu_rsp_valid=1, rdata stable until lsu_rsp_ready; on handshake -> IDLE; new request accepted no earlier than next cycle.
REQ-025 SHALL: minimum read latency, req handshake cycle N -> arvalid N+1 -> rvalid N+2 (zero-delay slave) -> rsp_valid N+3.
REQ-026 SHALL: size passed unmodified to arsize/awsize; no alignment, shifting or sign-extension (LSU owns it).
REQ-027 SHALL: all AXI valid/ready outputs and lsu_rsp_valid are registered (no combinational path from AXI inputs).

Reset
REQ-028 SHALL: on reset, state=IDLE, all valid/ready outputs 0 except lsu_req_ready=1, data registers 0, done flags cleared; in-flight transaction abandoned, no response issued.

Structure
REQ-029 SHALL: state encoding and LSU_AXI_ID (4'b0010) live in shared package lieat_axi_pkg; registers use lieat_general_dfflr; no sub-module beyond those flops.

Verification
REQ-030 SHALL: read addr 0x8000_0010 size 3, zero-delay slave returns 0x1122334455667788 -> arvalid at N+1, lsu_rsp_valid at N+3, rdata 0x1122334455667788.
REQ-031 SHALL: write addr 0x8000_0020 size 2 data 0xDEADBEEF, wready 3 cycles after awready -> awvalid drops after AW beat, wvalid holds until W beat, single B, rsp rdata 0.
REQ-032 SHALL: read with rid 0x1 beat then rid 0x2 beat -> first discarded, rsp carries second beat data.
REQ-033 SHALL: lsu_rsp_ready low 5 cycles in RSP -> rsp_valid/rdata stable, lsu_req_ready 0 throughout.
REQ-034 SHALL: reset asserted in RD_R -> next cycle IDLE, rready 0, lsu_req_ready 1, no lsu_rsp_valid.
